// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, LSU) and the register file
// write-port arbiter. The master side is the pipeline plus register file; the
// slave side is the arbiter itself.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  // Pipeline freeze
  logic              hold;

  // Requester A: ALU / execute result
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;

  // Requester B: load/store unit return data
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;

  // Register file write port (registered in the arbiter)
  logic              write_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] data;
  logic              last_src;

  modport master (
    output hold,
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready,
    input  write_enable, wr_address, data, last_src
  );

  modport slave (
    input  hold,
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready,
    output write_enable, wr_address, data, last_src
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the execute-stage result (A) and the load/store return path (B). Accepted
// writes appear on the registered write port exactly one cycle later.
// Writes that target x0 are accepted but never strobed into the file.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst,   // synchronous, active-low
  regfile_wb_arbiter_if.slave bus
);

  // Pointer encoding: which side wins when both are valid
  localparam logic PtrA = 1'b0;
  localparam logic PtrB = 1'b1;

  // Round-robin pointer
  logic ptr_q, ptr_d;

  // Output stage registers
  logic              we_q,   we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q,  src_d;

  // Grant decode
  logic grant_a, grant_b;
  logic allow;

  // Grants depend only on valids, hold, reset and the pointer, never on the
  // payload, so ready has no path from rd/data.
  always_comb begin
    allow   = rst && !bus.hold;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (allow) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = (ptr_q == PtrA);
        grant_b = (ptr_q == PtrB);
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Next pointer and next output-stage contents
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    if (grant_a) begin
      // Winner moves to the back of the queue
      ptr_d  = PtrB;
      we_d   = (bus.a_rd != '0);
      addr_d = bus.a_rd;
      data_d = bus.a_data;
      src_d  = 1'b0;
    end else if (grant_b) begin
      ptr_d  = PtrA;
      we_d   = (bus.b_rd != '0);
      addr_d = bus.b_rd;
      data_d = bus.b_data;
      src_d  = 1'b1;
    end
  end

  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= PtrA;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      src_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign bus.write_enable = we_q;
  assign bus.wr_address   = addr_q;
  assign bus.data         = data_q;
  assign bus.last_src     = src_q;

  // At most one grant per cycle
  a_onehot_grant : assert property (@(posedge clk) !(bus.a_ready && bus.b_ready));

  // Ready is only ever raised towards a requester that is asking
  a_ready_needs_valid : assert property (@(posedge clk)
    (!bus.a_ready || bus.a_valid) && (!bus.b_ready || bus.b_valid));

  // No acceptance while frozen or in reset
  a_no_grant_blocked : assert property (@(posedge clk)
    (!rst || bus.hold) |-> (!bus.a_ready && !bus.b_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts the
// grant each cycle and pushes the expected write-port contents into a queue;
// the entry is popped and compared once the registered stage has updated.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          src;
  } out_t;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  out_t exp_q[$];
  out_t m_prev;
  logic m_ptr;   // 0 = A next, 1 = B next

  // Reference grant from current stimulus and the bench's own pointer
  function automatic void model_grant(output logic ga, output logic gb);
    ga = 1'b0;
    gb = 1'b0;
    if (rst && !bus.hold) begin
      if (bus.a_valid && bus.b_valid) begin
        ga = !m_ptr;
        gb = m_ptr;
      end else begin
        ga = bus.a_valid;
        gb = bus.b_valid;
      end
    end
  endfunction

  function automatic out_t out_now();
    out_t o;
    o = {bus.write_enable, bus.wr_address, bus.data, bus.last_src};
    return o;
  endfunction

  // Predict the write port for this cycle, queue it, advance one clock
  task automatic tick();
    logic ga, gb;
    out_t e;
    model_grant(ga, gb);
    e    = m_prev;
    e.we = 1'b0;
    if (!rst) begin
      e     = '0;
      m_ptr = 1'b0;
    end else if (ga) begin
      e.we   = (bus.a_rd != '0);
      e.addr = bus.a_rd;
      e.data = bus.a_data;
      e.src  = 1'b0;
      m_ptr  = 1'b1;
    end else if (gb) begin
      e.we   = (bus.b_rd != '0);
      e.addr = bus.b_rd;
      e.data = bus.b_data;
      e.src  = 1'b1;
      m_ptr  = 1'b0;
    end
    m_prev = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e;
    logic ga, gb;
    rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h3333_3333;
    bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h4444_4444;
    for (int i = 0; i < 2; i++) begin
      #1;
      model_grant(ga, gb);
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b00 || {ga, gb} !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready got %b%b want 00", bus.a_ready, bus.b_ready);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (out_now() !== e || out_now() !== out_t'('0)) begin
        errors++;
        $display("FAIL reset_out got %h want %h", out_now(), e);
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    out_t e;
    logic ga, gb;
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    #1;
    model_grant(ga, gb);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || ga !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b%b want 10", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_write got %h want %h", out_now(), e);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || bus.write_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %h want %h", out_now(), e);
    end
  endtask

  task automatic test_contention();
    out_t e;
    logic ga, gb;
    // Pulse reset so the pointer starts at A
    rst = 1'b0;
    tick();
    void'(exp_q.pop_front());
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      model_grant(ga, gb);
      checks++;
      if ({bus.a_ready, bus.b_ready} !== {ga, gb} ||
          bus.a_ready !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL contention_grant%0d got %b%b want %b%b", i,
                 bus.a_ready, bus.b_ready, ga, gb);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (out_now() !== e || bus.data !== (((i % 2) == 0) ? 32'h11 : 32'h22)) begin
        errors++;
        $display("FAIL contention_write%0d got %h want %h", i, out_now(), e);
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic test_x0();
    out_t e;
    bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h1234;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_ready got %b%b want 01", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.b_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== {1'b0, 5'd0, 32'h1234, 1'b1}) begin
      errors++;
      $display("FAIL x0_drop got %h want %h", out_now(), e);
    end
  endtask

  task automatic test_hold();
    out_t e;
    logic ptr_before;
    ptr_before = m_ptr;
    bus.hold = 1'b1;
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hAAAA_0000;
    bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'hBBBB_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
        errors++;
        $display("FAIL hold_ready%0d got %b%b want 00", i, bus.a_ready, bus.b_ready);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (out_now() !== e || bus.write_enable !== 1'b0) begin
        errors++;
        $display("FAIL hold_out%0d got %h want %h", i, out_now(), e);
      end
    end
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.a_ready !== !ptr_before || bus.b_ready !== ptr_before) begin
      errors++;
      $display("FAIL hold_release got %b%b want %b%b", bus.a_ready, bus.b_ready,
               !ptr_before, ptr_before);
    end
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e) begin
      errors++;
      $display("FAIL hold_write got %h want %h", out_now(), e);
    end
  endtask

  task automatic test_collision();
    out_t e;
    // Lone A grant leaves the pointer on B
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e) begin
      errors++;
      $display("FAIL collide_prep got %h want %h", out_now(), e);
    end
    bus.a_rd = 5'd7; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hB;
    #1;
    checks++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL collide_first got %b%b want 01", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.b_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== {1'b1, 5'd7, 32'hB, 1'b1}) begin
      errors++;
      $display("FAIL collide_wb got %h want %h", out_now(), e);
    end
    #1;
    checks++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL collide_second got %b%b want 10", bus.a_ready, bus.b_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== {1'b1, 5'd7, 32'hA, 1'b0}) begin
      errors++;
      $display("FAIL collide_wa got %h want %h", out_now(), e);
    end
  endtask

  task automatic test_reset_midstream();
    out_t e;
    bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h9999;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready got %b want 0", bus.a_ready);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== out_t'('0)) begin
      errors++;
      $display("FAIL midrst_out got %h want %h", out_now(), e);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_retry got %b want 1", bus.a_ready);
    end
    tick();
    bus.a_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_now() !== e || out_now() !== {1'b1, 5'd9, 32'h9999, 1'b0}) begin
      errors++;
      $display("FAIL midrst_write got %h want %h", out_now(), e);
    end
  endtask

  task automatic test_back_to_back();
    out_t e;
    logic ga, gb;
    int   aw, bw;
    aw = 0;
    bw = 0;
    for (int i = 0; i < 80; i++) begin
      if (!bus.a_valid) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_rd    = AW'($urandom);
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b_rd    = AW'($urandom);
        bus.b_data  = $urandom;
      end
      #1;
      model_grant(ga, gb);
      checks++;
      if ({bus.a_ready, bus.b_ready} !== {ga, gb}) begin
        errors++;
        $display("FAIL b2b_grant%0d got %b%b want %b%b", i, bus.a_ready, bus.b_ready, ga, gb);
      end
      aw = (bus.a_valid && !bus.a_ready) ? aw + 1 : 0;
      bw = (bus.b_valid && !bus.b_ready) ? bw + 1 : 0;
      checks++;
      if (aw > 1 || bw > 1) begin
        errors++;
        $display("FAIL b2b_fair%0d got waits %0d/%0d want <=1", i, aw, bw);
      end
      tick();
      if (ga) bus.a_valid = 1'b0;
      if (gb) bus.b_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (out_now() !== e) begin
        errors++;
        $display("FAIL b2b_write%0d got %h want %h", i, out_now(), e);
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_ptr       = 1'b0;
    m_prev      = '0;
    rst         = 1'b0;
    bus.hold    = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_rd    = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_rd    = '0;
    bus.b_data  = '0;

    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_hold();
    test_collision();
    test_reset_midstream();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port A (ALU/execute result) and port B (load/store unit return data).
- Arbitrates with a round-robin policy and handles valid/ready handshakes on each requester.
- Drives the register file's write_enable, wr_address and data from a registered output stage, one cycle after acceptance.
- Sits between the execute/memory stages and the register file write port.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, width of destination register index

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
hold  input  1  pipeline freeze; while 1, no request is granted
a_valid  input  1  requester A has a writeback pending
a_ready  output  1  requester A accepted this cycle
a_rd  input  ADDR_W  requester A destination register
a_data  input  DATA_W  requester A write data
b_valid  input  1  requester B has a writeback pending
b_ready  output  1  requester B accepted this cycle
b_rd  input  ADDR_W  requester B destination register
b_data  input  DATA_W  requester B write data
write_enable  output  1  register file write strobe (registered)
wr_address  output  ADDR_W  register file write index (registered)
data  output  DATA_W  register file write data (registered)
last_src  output  1  source of the current write: 0=A, 1=B (registered)

Behaviour:
- Reset (rst==0 at a clock edge):
  - write_enable=0, wr_address=0, data=0, last_src=0.
  - Priority pointer set to A.
  - a_ready and b_ready forced to 0 while rst==0.
  - Reset mid-transfer discards any request presented that cycle. The requester must keep valid asserted and retry after reset.
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - x_ready is combinational from a_valid, b_valid, hold, rst and the pointer only. It never depends on x_rd or x_data.
  - Requesters keep valid, rd and data stable until accepted. Valid is never withdrawn before acceptance.
- Grant rules (rst==1, hold==0), at most one grant per cycle:
  - Only a_valid: grant A; pointer := B.
  - Only b_valid: grant B; pointer := A.
  - Both valid: grant the side named by the pointer; pointer := the other side.
  - Neither valid: no grant; pointer unchanged.
- hold==1: a_ready=b_ready=0; pointer unchanged. The output stage still updates normally (write_enable goes 0 next cycle).
- Output stage, 1-cycle latency:
  - On the edge following a transfer: write_enable=1, wr_address=granted rd, data=granted data, last_src=granted side.
  - Exception: if the granted rd==0, the transfer is still accepted (ready=1) but write_enable=0. wr_address, data and last_src update anyway.
  - With no transfer, write_enable=0 next cycle. wr_address, data and last_src hold their previous values.
- Fairness: with hold==0, a requester holding valid waits at most 1 cycle while the other is also valid.
- Same rd from both sides in one cycle: no merging. The two writes occur in consecutive cycles in grant order, so the later-granted value persists.
- Throughput: one write per cycle sustained. No internal buffering beyond the output register.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0; write_enable=0, wr_address=0, data=0 after reset edge.
2. Single requester: a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 same cycle; next cycle write_enable=1, wr_address=5, data=0xDEADBEEF, last_src=0; following cycle write_enable=0.
3. Contention: both valid for 4 cycles with a_rd=1/a_data=0x11 and b_rd=2/b_data=0x22, pointer=A after reset -> grants A,B,A,B; output writes 0x11,0x22,0x11,0x22 on cycles 2-5.
4. x0 drop: b_valid=1, b_rd=0, b_data=0x1234 -> b_ready=1; next cycle write_enable=0, last_src=1.
5. Hold: both valid, hold=1 for 3 cycles -> no readies, write_enable=0. Release hold -> grant follows the pointer value held before the freeze.
6. Same-destination collision: both valid, a_rd=b_rd=7, a_data=0xA, b_data=0xB, pointer=B -> writes 0xB then 0xA to register 7. Back-to-back write_enable=1 for 2 cycles.
